// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: data width, ResultSrc encodings
// and the memory-stage handshake FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/Register.sv
// Generic pipeline register with synchronous active-high reset and load enable.
module Register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= '0;
    end else if (En) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/dmem_handshake.sv
// Data-memory request/response FSM: drives dmem_req, computes the M-stage
// stall and flags the single cycle in which load data is accepted.
module dmem_handshake
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic is_store,
  input  logic is_load,
  input  logic dmem_gnt,
  input  logic dmem_rvalid,
  output logic dmem_req,
  output logic stall,
  output logic rdata_valid
);

  mem_state_t state, next_state;
  logic       access;
  logic       granted;

  assign access = is_store | is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MS_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    dmem_req    = 1'b0;
    granted     = 1'b0;
    rdata_valid = 1'b0;
    case (state)
      MS_IDLE: begin
        if (access) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            granted    = 1'b1;
            next_state = is_load ? MS_RESP : MS_IDLE;
          end else begin
            next_state = MS_REQ;
          end
        end
      end
      MS_REQ: begin
        // Inputs are frozen by the stall, so access should stay asserted here
        if (access) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            granted    = 1'b1;
            next_state = is_load ? MS_RESP : MS_IDLE;
          end
        end else begin
          next_state = MS_IDLE;
        end
      end
      MS_RESP: begin
        if (dmem_rvalid) begin
          rdata_valid = 1'b1;
          next_state  = MS_IDLE;
        end
      end
      default: next_state = MS_IDLE;
    endcase
  end

  assign stall = (is_store & ~granted) | (is_load & ~rdata_valid);

endmodule

// File: rtl/mux3X1.sv
// Three-input mux; the unused fourth select code falls back to input 0.
module mux3X1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'b01:   out = in1;
      2'b10:   out = in2;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: issues data-memory accesses, stalls the pipeline front while
// one is outstanding, and holds the M/W registers plus writeback mux.
module memory_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            MemWriteM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            StallM,
  output logic [XLEN-1:0] ResultW,
  output logic [4:0]      RdW,
  output logic            RegWriteW
);

  import riscv_pkg::*;

  localparam int MW_WIDTH = 3 * XLEN + 5 + 1 + 2;

  logic            is_store;
  logic            is_load;
  logic            rdata_valid;
  logic [XLEN-1:0] read_data_next;
  logic [XLEN-1:0] ALUResultW;
  logic [XLEN-1:0] ReadDataW;
  logic [XLEN-1:0] PCPlus4W;
  logic [1:0]      ResultSrcW;
  logic [4:0]      rd_next;
  logic            reg_write_next;
  logic [MW_WIDTH-1:0] mw_d;
  logic [MW_WIDTH-1:0] mw_q;

  // A simultaneous store+load decode resolves as a store
  assign is_store = MemWriteM;
  assign is_load  = (ResultSrcM == RES_MEM) & ~MemWriteM;

  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUResultM;
  assign dmem_wdata = WriteDataM;

  dmem_handshake u_handshake (
    .clk         (clk),
    .rst         (rst),
    .is_store    (is_store),
    .is_load     (is_load),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_req    (dmem_req),
    .stall       (StallM),
    .rdata_valid (rdata_valid)
  );

  // Read data only updates on an accepted response so stray rvalids are harmless
  assign read_data_next = rdata_valid ? dmem_rdata : ReadDataW;
  assign rd_next        = StallM ? 5'd0 : RdM;
  assign reg_write_next = StallM ? 1'b0 : RegWriteM;

  assign mw_d = {ALUResultM, read_data_next, PCPlus4M, rd_next, reg_write_next, ResultSrcM};

  Register #(.WIDTH(MW_WIDTH)) u_mw_reg (
    .clk (clk),
    .rst (rst),
    .En  (1'b1),
    .D   (mw_d),
    .Q   (mw_q)
  );

  assign {ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW} = mw_q;

  mux3X1 #(.WIDTH(XLEN)) u_result_mux (
    .in0 (ALUResultW),
    .in1 (ReadDataW),
    .in2 (PCPlus4W),
    .sel (ResultSrcW),
    .out (ResultW)
  );

endmodule
